// File: rtl/sdram_sim_pkg.sv
// rtl/sdram_sim_pkg.sv - shared op encodings, FSM states and defaults for the SDRAM model
package sdram_sim_pkg;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_REFRESH = 2'd2
    } op_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam int          DEFAULT_LATENCY  = 4;
    localparam int unsigned DEFAULT_MEM_SIZE = 32'h0800_0000;

endpackage

// File: rtl/sdram_sim_array.sv
// rtl/sdram_sim_array.sv - byte-lane storage with a word read port and byte-enable write port
module sdram_sim_array #(
    parameter int unsigned MEM_SIZE = 32'h0800_0000,
    localparam int         AW       = $clog2(MEM_SIZE / 4)
) (
    input  logic          CLK,
    input  logic [AW-1:0] w_rd_idx,
    output logic [31:0]   w_rdata,
    input  logic          w_we,
    input  logic [AW-1:0] w_wr_idx,
    input  logic [31:0]   w_wdata,
    input  logic [3:0]    w_mask
);

    // Byte array kept at this name so benches can preload it hierarchically.
    logic [7:0] mem [0:MEM_SIZE-1];

    assign w_rdata = {mem[{w_rd_idx, 2'd3}], mem[{w_rd_idx, 2'd2}],
                      mem[{w_rd_idx, 2'd1}], mem[{w_rd_idx, 2'd0}]};

    always_ff @(posedge CLK) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mask[i]) begin
                    mem[{w_wr_idx, 2'(i)}] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/sdram_sim.sv
// rtl/sdram_sim.sv - cycle-approximate SDRAM word-port model with a fixed-latency busy window
module sdram_sim
    import sdram_sim_pkg::*;
#(
    parameter int unsigned MEM_SIZE = DEFAULT_MEM_SIZE,
    parameter int          LATENCY  = DEFAULT_LATENCY
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] w_addr,
    output logic [31:0] w_odata,
    input  logic        w_we,
    input  logic        w_le,
    input  logic [31:0] w_wdata,
    input  logic [3:0]  w_mask,
    output logic        w_stall,
    input  logic [31:0] w_mtime,
    input  logic        w_refresh
);

    localparam int AW = $clog2(MEM_SIZE / 4);
    localparam int CW = $clog2(LATENCY) + 1;

    state_t        r_state;
    op_t           r_op;
    logic [CW-1:0] r_cnt;
    logic [AW-1:0] r_idx;
    logic [31:0]   r_wdata;
    logic [3:0]    r_mask;
    logic          r_stall;
    logic [31:0]   r_odata;

    logic          w_done;
    logic          w_arr_we;
    logic [31:0]   w_rdata;
    logic          w_unused;

    assign w_done   = (r_state == ST_BUSY) && (r_cnt == '0);
    assign w_arr_we = w_done && (r_op == OP_WRITE);
    assign w_stall  = r_stall;
    assign w_odata  = r_odata;
    // Timestamp and out-of-range address bits have no functional effect.
    assign w_unused = ^{w_mtime, w_addr};

    sdram_sim_array #(
        .MEM_SIZE (MEM_SIZE)
    ) u_array (
        .CLK      (CLK),
        .w_rd_idx (r_idx),
        .w_rdata  (w_rdata),
        .w_we     (w_arr_we),
        .w_wr_idx (r_idx),
        .w_wdata  (r_wdata),
        .w_mask   (r_mask)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_op    <= OP_READ;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wdata <= '0;
            r_mask  <= '0;
            r_stall <= 1'b0;
            r_odata <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_we || w_le || w_refresh) begin
                        r_op    <= w_we ? OP_WRITE : (w_le ? OP_READ : OP_REFRESH);
                        r_idx   <= w_addr[AW+1:2];
                        r_wdata <= w_wdata;
                        r_mask  <= w_mask;
                        r_cnt   <= CW'(LATENCY - 1);
                        r_stall <= 1'b1;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // The array commits a write on this same edge via w_arr_we.
                    if (r_cnt == '0) begin
                        if (r_op == OP_READ) begin
                            r_odata <= w_rdata;
                        end
                        r_stall <= 1'b0;
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_sim.sv
// tb/tb_sdram_sim.sv - directed table-driven bench for the SDRAM word-port model
module tb_sdram_sim;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [31:0] w_addr = '0;
    logic [31:0] w_odata;
    logic        w_we = 1'b0;
    logic        w_le = 1'b0;
    logic [31:0] w_wdata = '0;
    logic [3:0]  w_mask = '0;
    logic        w_stall;
    logic [31:0] w_mtime = '0;
    logic        w_refresh = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          op;      // 0 read, 1 write, 2 refresh
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        logic [31:0] exp_odata;
    } vec_t;

    vec_t vecs [0:10];

    sdram_sim #(
        .MEM_SIZE (4096),
        .LATENCY  (4)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .w_addr    (w_addr),
        .w_odata   (w_odata),
        .w_we      (w_we),
        .w_le      (w_le),
        .w_wdata   (w_wdata),
        .w_mask    (w_mask),
        .w_stall   (w_stall),
        .w_mtime   (w_mtime),
        .w_refresh (w_refresh)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) w_mtime <= w_mtime + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input int addr, input logic [31:0] word);
        for (int i = 0; i < 4; i++) dut.u_array.mem[addr + i] = word[8*i +: 8];
    endtask

    // Issues one request, drops it once accepted, returns the number of stall cycles.
    task automatic run_op(input logic we, input logic le, input logic rf,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] mask, output int cyc);
        @(negedge CLK);
        w_we = we; w_le = le; w_refresh = rf;
        w_addr = addr; w_wdata = wdata; w_mask = mask;
        @(posedge CLK); #1;
        w_we = 1'b0; w_le = 1'b0; w_refresh = 1'b0;
        cyc = 0;
        while (w_stall && cyc < 20) begin
            cyc++;
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        int cyc;

        vecs[0]  = '{1, 32'h0000_0100, 32'hDEAD_BEEF, 4'b1111, 32'h0000_0000};
        vecs[1]  = '{0, 32'h0000_0100, 32'h0,         4'b0000, 32'hDEAD_BEEF};
        vecs[2]  = '{1, 32'h0000_0200, 32'h0000_AA00, 4'b0010, 32'hDEAD_BEEF};
        vecs[3]  = '{0, 32'h0000_0200, 32'h0,         4'b0000, 32'h1122_AA44};
        vecs[4]  = '{2, 32'h0000_0000, 32'h0,         4'b0000, 32'h1122_AA44};
        vecs[5]  = '{0, 32'h0000_0102, 32'h0,         4'b0000, 32'hDEAD_BEEF};
        vecs[6]  = '{1, 32'h0000_1008, 32'h0000_0055, 4'b0001, 32'hDEAD_BEEF};
        vecs[7]  = '{0, 32'h0000_0008, 32'h0,         4'b0000, 32'h0000_0055};
        vecs[8]  = '{1, 32'h0000_0304, 32'hCAFE_F00D, 4'b0000, 32'h0000_0055};
        vecs[9]  = '{0, 32'h0000_0304, 32'h0,         4'b0000, 32'h0102_0304};
        vecs[10] = '{0, 32'h0000_0200, 32'h0,         4'b0000, 32'h1122_AA44};

        preload(32'h200, 32'h1122_3344);
        preload(32'h008, 32'h0000_0000);
        preload(32'h304, 32'h0102_0304);
        preload(32'h400, 32'h0000_0000);
        preload(32'h500, 32'h0BAD_F00D);

        repeat (2) @(posedge CLK);
        #1;
        check("reset_stall", {31'b0, w_stall}, 32'h0);
        check("reset_odata", w_odata, 32'h0);
        @(negedge CLK);
        RST = 1'b0;

        for (int v = 0; v < 11; v++) begin
            run_op(vecs[v].op == 1, vecs[v].op == 0, vecs[v].op == 2,
                   vecs[v].addr, vecs[v].wdata, vecs[v].mask, cyc);
            check($sformatf("vec%0d_stall_cycles", v), cyc, 4);
            check($sformatf("vec%0d_odata", v), w_odata, vecs[v].exp_odata);
        end

        // Write wins over a coincident read; a read held during BUSY is ignored.
        @(negedge CLK);
        w_we = 1'b1; w_le = 1'b1; w_addr = 32'h400; w_wdata = 32'h1234_5678; w_mask = 4'b1111;
        @(posedge CLK); #1;
        w_we = 1'b0;
        check("prio_stall_up", {31'b0, w_stall}, 32'h1);
        repeat (2) @(posedge CLK);
        #1;
        w_le = 1'b0;
        cyc = 2;
        while (w_stall && cyc < 20) begin
            cyc++;
            @(posedge CLK); #1;
        end
        check("prio_stall_cycles", cyc, 4);
        check("prio_odata_kept", w_odata, 32'h1122_AA44);
        @(posedge CLK); #1;
        check("busy_read_dropped", {31'b0, w_stall}, 32'h0);
        run_op(1'b0, 1'b1, 1'b0, 32'h400, 32'h0, 4'b0, cyc);
        check("prio_write_data", w_odata, 32'h1234_5678);

        // A read still held after completion starts a fresh operation.
        @(negedge CLK);
        w_le = 1'b1; w_addr = 32'h200;
        @(posedge CLK); #1;
        cyc = 0;
        while (w_stall && cyc < 20) begin
            cyc++;
            @(posedge CLK); #1;
        end
        check("held_first_cycles", cyc, 4);
        check("held_first_odata", w_odata, 32'h1122_AA44);
        @(posedge CLK); #1;
        w_le = 1'b0;
        check("held_restart_stall", {31'b0, w_stall}, 32'h1);
        cyc = 0;
        while (w_stall && cyc < 20) begin
            cyc++;
            @(posedge CLK); #1;
        end
        check("held_restart_cycles", cyc, 4);

        // Reset on the second busy cycle discards the pending write.
        @(negedge CLK);
        w_we = 1'b1; w_addr = 32'h500; w_wdata = 32'hFFFF_FFFF; w_mask = 4'b1111;
        @(posedge CLK); #1;
        w_we = 1'b0;
        check("rst_busy_stall", {31'b0, w_stall}, 32'h1);
        @(posedge CLK); #1;
        RST = 1'b1;
        #1;
        check("rst_async_stall", {31'b0, w_stall}, 32'h0);
        check("rst_async_odata", w_odata, 32'h0);
        @(negedge CLK);
        RST = 1'b0;
        repeat (5) @(posedge CLK);
        #1;
        check("rst_idle_stall", {31'b0, w_stall}, 32'h0);
        run_op(1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 4'b0, cyc);
        check("rst_read_cycles", cyc, 4);
        check("rst_word_kept", w_odata, 32'h0BAD_F00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_sim.md
Name: sdram_sim

Overview:
- Cycle-approximate behavioural model of the SDRAM word port behind the DRAM controller.
- Used in simulation builds in place of the real SDRAM controller and device.
- Accepts word-aligned read, write and refresh requests, applies byte-lane write masks, and reports a multi-cycle busy (stall) window.
- The controller's level-request / wait-busy-high / wait-busy-low handshake works against it unchanged.

Parameters:
- MEM_SIZE, default 32'h0800_0000: storage size in bytes; power of two.
- LATENCY, default 4: cycles w_stall stays high per operation; must be ≥2.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
- w_addr  in  32  byte address; bits [1:0] ignored (word access).
- w_odata  out  32  read data, little-endian word.
- w_we  in  1  write request (level).
- w_le  in  1  read (load) request (level).
- w_wdata  in  32  write data, pre-aligned to byte lanes.
- w_mask  in  4  active-high byte enables; bit i writes w_wdata[8i+7:8i].
- w_stall  out  1  busy.
- w_mtime  in  32  timestamp for debug trace only; no functional effect.
- w_refresh  in  1  refresh request (level).

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high (RST).
- Reset values: w_stall=0, w_odata=0, FSM=IDLE, counter=0. Storage is not cleared by reset.
- Storage: byte array "mem" [0:MEM_SIZE-1], hierarchically writable for preload.
- Word index = w_addr[31:2] modulo MEM_SIZE/4, so addresses wrap.
- FSM has two states, IDLE and BUSY; a latched operation register holds OP ∈ {READ, WRITE, REFRESH}.
- IDLE, request priority when requests coincide: w_we > w_le > w_refresh.
- IDLE, on a sampled request:
  - latch address, wdata, mask and op;
  - set w_stall=1 (visible the cycle after the request edge);
  - load counter=LATENCY-1; go to BUSY.
- IDLE with no request: nothing happens.
- BUSY: counter decrements each cycle. When it reaches 0, at that edge:
  - READ: w_odata <= mem word at latched address.
  - WRITE: write only the masked bytes; mask 0 writes nothing.
  - REFRESH: no data change.
  - w_stall <= 0; go to IDLE.
- w_stall is high for exactly LATENCY cycles.
- w_odata holds its value until the next read completes; writes and refresh do not alter it.
- Requests asserted during BUSY are ignored, not queued. Requests still high on the IDLE re-entry edge start a new operation.
- The controller deasserts its request once it sees w_stall=1, so the single-cycle overlap after acceptance is harmless.
- Write-then-read of the same word returns the new data; the write commits before the next operation can start.
- RST during BUSY aborts the operation: a pending write is discarded, w_stall=0 immediately.
- Optional $display trace under `ifdef SDRAM_SIM_TRACE, prefixed with w_mtime; no functional effect.

Decomposition:
- Shared package/define file holds OP encodings (READ=0, WRITE=1, REFRESH=2), the default LATENCY, and the default MEM_SIZE (`MEM_SIZE from define.vh).
- One natural sub-module, sdram_sim_array: byte-lane RAM with a word read port and a 4-bit byte-enable write port.

Test Plan:
- Write then read, aligned: w_we at addr 0x100, wdata 0xDEADBEEF, mask 4'b1111.
  - Expect: w_stall high 4 cycles.
  - Then read 0x100 → w_odata=0xDEADBEEF on the edge w_stall falls.
- Byte mask: preload 0x11223344 at 0x200; write wdata 0x0000AA00, mask 4'b0010.
  - Expect: read returns 0x1122AA44.
- Refresh: assert w_refresh one cycle.
  - Expect: w_stall high 4 cycles; w_odata unchanged; memory contents unchanged.
- Priority and busy: assert w_we and w_le together; then assert w_le for 2 cycles while busy.
  - Expect: write executes; the read is ignored during BUSY.
  - Expect: a read held into IDLE starts a new operation.
- Wrap: with MEM_SIZE=4096, write 0x55 mask 4'b0001 to address 4096+8.
  - Expect: read of address 8 returns LSB 0x55.
- Reset mid-write: assert RST on the 2nd busy cycle.
  - Expect: w_stall=0 immediately; target word keeps its old value.
